// File: rtl/dmux_router.sv
// dmux_router: 1-to-WAYS demultiplexer with one registered slot per lane.
// A single producer hands WIDTH-bit words over a valid/ready handshake; each
// word lands in the slot of lane in_sel, or in every slot when in_bcast is set.
// Idle lanes present zero data. An accepted word whose select names no lane
// is dropped and latches the sticky err_sel flag until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake (in_ready is combinational)
//   in_data, in_sel     word and destination lane index
//   in_bcast            deliver to all lanes, in_sel ignored
//   out_valid/out_ready per-lane consumer handshake
//   out_data            lane i at bits [i*WIDTH +: WIDTH]
//   err_sel             sticky out-of-range select indicator
module dmux_router #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [WAYS-1:0]         out_valid,
  input  logic [WAYS-1:0]         out_ready,
  output logic [WAYS*WIDTH-1:0]   out_data,
  output logic                    err_sel
);

  logic [WAYS-1:0]             free;
  logic [WAYS-1:0]             hit;
  logic [WAYS-1:0]             drain;
  logic [WAYS-1:0]             load;
  logic                        sel_in_range;
  logic                        accept;
  logic                        drop;
  logic [WAYS-1:0][WIDTH-1:0]  data_q;

  // Slot status, handshake and per-lane load/drain decisions.
  always_comb begin
    free         = '0;
    hit          = '0;
    drain        = '0;
    load         = '0;
    sel_in_range = 1'b0;
    in_ready     = 1'b0;
    accept       = 1'b0;
    drop         = 1'b0;

    for (int i = 0; i < int'(WAYS); i++) begin
      // A slot being drained this cycle can take a new word without a bubble.
      free[i]  = !out_valid[i] || out_ready[i];
      hit[i]   = (in_sel == SEL_W'(i));
      drain[i] = out_valid[i] && out_ready[i];
    end
    sel_in_range = |hit;

    // Out-of-range selects are always accepted so the producer never stalls.
    if (in_bcast)
      in_ready = &free;
    else if (sel_in_range)
      in_ready = |(hit & free);
    else
      in_ready = 1'b1;

    accept = in_valid && in_ready;
    drop   = accept && !in_bcast && !sel_in_range;

    for (int i = 0; i < int'(WAYS); i++)
      load[i] = accept && (in_bcast || hit[i]);
  end

  // Lane slots: reload wins over drain; a drained slot returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      data_q    <= '0;
    end else begin
      for (int i = 0; i < int'(WAYS); i++) begin
        if (load[i]) begin
          out_valid[i] <= 1'b1;
          data_q[i]    <= in_data;
        end else if (drain[i]) begin
          out_valid[i] <= 1'b0;
          data_q[i]    <= '0;
        end
      end
    end
  end

  // Sticky error flag for dropped out-of-range words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sel <= 1'b0;
    else if (drop)
      err_sel <= 1'b1;
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_dmux_router.sv
// Directed testbench for dmux_router: an 8-lane instance covers reset,
// unicast, back-pressure, broadcast and async reset; a 6-lane instance
// covers out-of-range selects and the sticky error flag.
module tb_dmux_router;

  localparam int unsigned W   = 16;
  localparam int unsigned N8  = 8;
  localparam int unsigned N6  = 6;

  logic            clk;
  logic            rst_n;

  logic            in_valid, in_ready, in_bcast, err_sel;
  logic [W-1:0]    in_data;
  logic [2:0]      in_sel;
  logic [N8-1:0]   out_valid, out_ready;
  logic [N8*W-1:0] out_data;

  logic            in_valid6, in_ready6, in_bcast6, err_sel6;
  logic [W-1:0]    in_data6;
  logic [2:0]      in_sel6;
  logic [N6-1:0]   out_valid6, out_ready6;
  logic [N6*W-1:0] out_data6;

  int total;
  int bad;

  dmux_router #(.WIDTH(W), .WAYS(N8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel)
  );

  dmux_router #(.WIDTH(W), .WAYS(N6), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .in_sel(in_sel6), .in_bcast(in_bcast6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
    .err_sel(err_sel6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N8*W-1:0] zero8;
    zero8 = '0;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_sel = 3'd5;
    out_ready = 8'hFF;
    tick(); tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
    total++; if (out_data !== zero8) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (err_sel !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_sel); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL idle_valid got=%h exp=00", out_valid); end
    total++; if (out_data !== zero8) begin bad++; $display("FAIL idle_data got=%h exp=0", out_data); end
  endtask

  task automatic test_unicast();
    logic [N8*W-1:0] exp;
    exp = '0;
    exp[5*W +: W] = 16'hBEEF;
    out_ready = 8'hFF; in_bcast = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF; in_sel = 3'd5;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 8'h20) begin bad++; $display("FAIL uni_valid got=%h exp=20", out_valid); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL uni_data got=%h exp=%h", out_data, exp); end
    tick();
    exp = '0;
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL uni_drain_valid got=%h exp=00", out_valid); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL uni_drain_data got=%h exp=0", out_data); end
  endtask

  task automatic test_back_pressure();
    out_ready = 8'hFB; in_bcast = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; in_sel = 3'd2;
    tick();
    in_data = 16'h2222;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
    total++; if (out_data[2*W +: W] !== 16'h1111) begin bad++; $display("FAIL bp_first got=%h exp=1111", out_data[2*W +: W]); end
    tick();
    total++; if (out_data[2*W +: W] !== 16'h1111) begin bad++; $display("FAIL bp_hold got=%h exp=1111", out_data[2*W +: W]); end
    total++; if (out_valid !== 8'h04) begin bad++; $display("FAIL bp_hold_valid got=%h exp=04", out_valid); end
    out_ready = 8'hFF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 8'h04) begin bad++; $display("FAIL bp_nobubble_valid got=%h exp=04", out_valid); end
    total++; if (out_data[2*W +: W] !== 16'h2222) begin bad++; $display("FAIL bp_second got=%h exp=2222", out_data[2*W +: W]); end
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL bp_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_broadcast();
    logic [N8*W-1:0] exp;
    out_ready = 8'hF7; in_bcast = 1'b0;
    in_valid = 1'b1; in_data = 16'h3333; in_sel = 3'd3;
    tick();
    in_bcast = 1'b1; in_data = 16'hA5A5; in_sel = 3'd0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked_ready got=%b exp=0", in_ready); end
    tick();
    exp = '0;
    exp[3*W +: W] = 16'h3333;
    total++; if (out_valid !== 8'h08) begin bad++; $display("FAIL bc_blocked_valid got=%h exp=08", out_valid); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL bc_blocked_data got=%h exp=%h", out_data, exp); end
    out_ready = 8'hFF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    exp = {N8{16'hA5A5}};
    total++; if (out_valid !== 8'hFF) begin bad++; $display("FAIL bc_valid got=%h exp=FF", out_valid); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL bc_data got=%h exp=%h", out_data, exp); end
    tick();
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL bc_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_out_of_range();
    out_ready6 = 6'h3F; in_bcast6 = 1'b0;
    in_valid6 = 1'b1; in_data6 = 16'hDEAD; in_sel6 = 3'd7;
    #1;
    total++; if (in_ready6 !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b exp=1", in_ready6); end
    total++; if (err_sel6 !== 1'b0) begin bad++; $display("FAIL oor_err_before got=%b exp=0", err_sel6); end
    tick();
    in_sel6 = 3'd6; in_data6 = 16'hFACE;
    tick();
    total++; if (out_valid6 !== 6'h00) begin bad++; $display("FAIL oor_valid got=%h exp=00", out_valid6); end
    total++; if (err_sel6 !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", err_sel6); end
    in_sel6 = 3'd5; in_data6 = 16'h5555;
    tick();
    in_valid6 = 1'b0;
    total++; if (out_valid6 !== 6'h20) begin bad++; $display("FAIL oor_lane5_valid got=%h exp=20", out_valid6); end
    total++; if (out_data6[5*W +: W] !== 16'h5555) begin bad++; $display("FAIL oor_lane5_data got=%h exp=5555", out_data6[5*W +: W]); end
    total++; if (err_sel6 !== 1'b1) begin bad++; $display("FAIL oor_err_sticky got=%b exp=1", err_sel6); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (err_sel6 !== 1'b0) begin bad++; $display("FAIL oor_err_reset got=%b exp=0", err_sel6); end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    logic [N8*W-1:0] zero8;
    zero8 = '0;
    out_ready = 8'h00; in_bcast = 1'b0;
    in_valid = 1'b1; in_data = 16'h0A0A; in_sel = 3'd0;
    tick();
    in_data = 16'h4444; in_sel = 3'd4;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 8'h11) begin bad++; $display("FAIL ar_full got=%h exp=11", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL ar_valid got=%h exp=00", out_valid); end
    total++; if (out_data !== zero8) begin bad++; $display("FAIL ar_data got=%h exp=0", out_data); end
    #2;
    rst_n = 1'b1;
    tick();
    out_ready = 8'hFF;
    in_valid = 1'b1; in_data = 16'h6666; in_sel = 3'd6;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 8'h40) begin bad++; $display("FAIL ar_after_valid got=%h exp=40", out_valid); end
    total++; if (out_data[6*W +: W] !== 16'h6666) begin bad++; $display("FAIL ar_after_data got=%h exp=6666", out_data[6*W +: W]); end
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    in_valid6 = 1'b0; in_data6 = '0; in_sel6 = '0; in_bcast6 = 1'b0; out_ready6 = '0;
    test_reset();
    test_unicast();
    test_back_pressure();
    test_broadcast();
    test_out_of_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux_router.md
Name: dmux_router

Overview:
Parametrised 1-to-WAYS demultiplexer for WIDTH-bit words with a registered output slot per lane and valid/ready handshaking. It extends the plain 16-bit two-way demultiplexer with four additions: a configurable lane count, back-pressure, a broadcast mode, and a sticky flag for out-of-range selects. It sits between a single producer (CPU bus, memory read path) and WAYS independent consumers.

Parameters:
WIDTH, 16, data word width in bits (>=1)
WAYS, 8, number of output lanes (>=2; need not be a power of two)
SEL_W, 3, select width in bits; must satisfy 2**SEL_W >= WAYS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  router accepts the word this cycle
in_data  input  WIDTH  word to route
in_sel  input  SEL_W  destination lane index
in_bcast  input  1  1 = deliver to all lanes; in_sel ignored
out_valid  output  WAYS  per-lane slot occupied
out_ready  input  WAYS  per-lane consumer accepts
out_data  output  WAYS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
err_sel  output  1  sticky: out-of-range select was accepted

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid = 0, all out_data = 0, err_sel = 0. Effect is immediate and persists while rst_n is low. Any in-flight word is lost. On deassertion, operation starts at the next rising edge.
- Lane slot i is "free" when !out_valid[i] || out_ready[i], i.e. it is empty or being drained this cycle.
- in_ready is combinational, with no dependence on in_valid:
  - bcast = 1: AND of free over all lanes.
  - bcast = 0 and in_sel < WAYS: free[in_sel].
  - bcast = 0 and in_sel >= WAYS: 1.
- Accept = in_valid && in_ready, sampled at the rising edge.
- Unicast accept with in_sel < WAYS: slot in_sel loads in_data, and out_valid[in_sel] = 1 from the next cycle. Latency is 1 cycle. Other lanes are unaffected.
- Broadcast accept: every slot loads in_data, and all out_valid are 1 next cycle.
- Out-of-range accept (in_sel >= WAYS, bcast = 0): the word is dropped, no lane changes, and err_sel becomes 1. err_sel stays 1 until reset.
- Drain: out_valid[i] && out_ready[i] with no reload of lane i on the same edge gives out_valid[i] = 0 and out_data lane i = 0 next cycle. Idle lanes therefore always present zero, matching the zero-fill of unselected outputs in the combinational demux.
- Simultaneous drain and reload of the same lane: the new word wins, out_valid stays 1, and there is no bubble. Full throughput is 1 word/cycle per lane.
- out_valid[i] is never deasserted without out_ready[i]. out_data lane i is stable while out_valid[i] && !out_ready[i].
- in_valid low: no state changes except drains.
- Fully synchronous datapath; no combinational path from in_data to out_data.
- Combinational path out_ready -> in_ready is intentional; producers must not make in_valid depend on in_ready.

Test Plan:
- Reset/idle: hold rst_n = 0 with in_valid = 1 -> out_valid = 0x00, all out_data = 0, err_sel = 0. Release with in_valid = 0 -> nothing changes.
- Unicast: WAYS = 8, out_ready = 0xFF; in_data = 0xBEEF, in_sel = 5 for one cycle -> next cycle out_valid = 0x20, lane5 = 0xBEEF, other lanes 0. Following cycle out_valid = 0x00, lane5 = 0.
- Back-pressure: out_ready[2] = 0; send 0x1111 then 0x2222 to lane 2 -> second cycle in_ready = 0, lane2 holds 0x1111. Raise out_ready[2] -> in_ready = 1 the same cycle, 0x2222 loads with no bubble.
- Broadcast: out_ready = 0xFF except bit 3 = 0 and lane 3 full; in_bcast = 1, in_data = 0xA5A5 -> in_ready = 0 and no lane changes. Drain lane 3 -> accept, all 8 lanes = 0xA5A5 next cycle.
- Out-of-range: WAYS = 6, SEL_W = 3, in_sel = 7, in_valid = 1 -> in_ready = 1, no lane valid, err_sel = 1 and stays 1 through later traffic until rst_n pulses low.
- Async reset mid-transfer: lanes 0 and 4 full; pulse rst_n low between clock edges -> outputs clear immediately, without waiting for an edge. Words sent after release route normally.
